// File: rtl/demux_bank.sv
// ---------------------------------------------------------------------------
// demux_bank / demux_core
//
// Purpose:
//   Three independent registered 1-to-N demultiplexers sharing one clock and
//   one synchronous active-low reset. Each channel steers its input data to
//   the lane picked by its select. Every other lane is driven to zero on the
//   same edge, so no stale data is held on a lane that is no longer selected.
//   All outputs come straight from flops, so there is no combinational path
//   from any input to any output.
//
// demux_bank ports:
//   inClk       in   1   clock, all state updates on the rising edge
//   inRst_n     in   1   synchronous reset, active low
//   inData181   in   1   ch181 data
//   inSel181    in   3   ch181 select (0..7)
//   outData181  out  8   ch181 lanes, bit i = lane i
//   inData121   in   1   ch121 data
//   inSel121    in   1   ch121 select (0..1)
//   outData121  out  2   ch121 lanes, bit i = lane i
//   inData124   in   4   ch124 data nibble
//   inSel124    in   2   ch124 select (0..3)
//   outData124  out 16   ch124 lanes, lane i = outData124[4*i+3:4*i]
//
// demux_core ports:
//   clk, rstN            clock and synchronous active-low reset
//   inData   [W-1:0]     data to route
//   inSel    [SW-1:0]    lane select
//   outData  [N*W-1:0]   registered lanes, lane i = outData[W*i +: W]
// ---------------------------------------------------------------------------

module demux_core #(
  parameter int N  = 8,
  parameter int W  = 1,
  // A 1-lane demux still needs a 1-bit select port to stay legal.
  parameter int SW = (N > 1) ? $clog2(N) : 1
) (
  input  logic            clk,
  input  logic            rstN,
  input  logic [W-1:0]    inData,
  input  logic [SW-1:0]   inSel,
  output logic [N*W-1:0]  outData
);

  logic [N*W-1:0] nextData_s;
  logic [N*W-1:0] data_r;

  // Build the one-hot-by-select lane image for the next edge.
  always_comb begin
    nextData_s = {(N*W){1'b0}};
    for (int i = 0; i < N; i++) begin
      if (inSel == i[SW-1:0]) begin
        nextData_s[W*i +: W] = inData;
      end else begin
        nextData_s[W*i +: W] = {W{1'b0}};
      end
    end
  end

  // Output register with synchronous active-low reset; reset wins over data.
  always_ff @(posedge clk) begin
    if (!rstN) begin
      data_r <= {(N*W){1'b0}};
    end else begin
      data_r <= nextData_s;
    end
  end

  assign outData = data_r;

endmodule

module demux_bank #(
  parameter int N181 = 8,
  parameter int N121 = 2,
  parameter int N124 = 4,
  parameter int W124 = 4
) (
  input  logic                    inClk,
  input  logic                    inRst_n,
  input  logic                    inData181,
  input  logic [$clog2(N181)-1:0] inSel181,
  output logic [N181-1:0]         outData181,
  input  logic                    inData121,
  input  logic [$clog2(N121)-1:0] inSel121,
  output logic [N121-1:0]         outData121,
  input  logic [W124-1:0]         inData124,
  input  logic [$clog2(N124)-1:0] inSel124,
  output logic [N124*W124-1:0]    outData124
);

  demux_core #(.N(N181), .W(1), .SW($clog2(N181))) u_ch181 (
    .clk     (inClk),
    .rstN    (inRst_n),
    .inData  (inData181),
    .inSel   (inSel181),
    .outData (outData181)
  );

  demux_core #(.N(N121), .W(1), .SW($clog2(N121))) u_ch121 (
    .clk     (inClk),
    .rstN    (inRst_n),
    .inData  (inData121),
    .inSel   (inSel121),
    .outData (outData121)
  );

  demux_core #(.N(N124), .W(W124), .SW($clog2(N124))) u_ch124 (
    .clk     (inClk),
    .rstN    (inRst_n),
    .inData  (inData124),
    .inSel   (inSel124),
    .outData (outData124)
  );

endmodule

// File: tb/tb_demux_bank.sv
// ---------------------------------------------------------------------------
// tb_demux_bank
//
// Scoreboard bench for demux_bank. The driver applies inputs on the falling
// edge and pushes the response expected after the next rising edge; the
// monitor samples just after each rising edge and pops/compares whenever an
// expectation is pending. Expected values come from shift arithmetic on the
// applied inputs, not from the design.
// ---------------------------------------------------------------------------

module tb_demux_bank;

  logic        inClk;
  logic        inRst_n;
  logic        inData181;
  logic [2:0]  inSel181;
  logic [7:0]  outData181;
  logic        inData121;
  logic [0:0]  inSel121;
  logic [1:0]  outData121;
  logic [3:0]  inData124;
  logic [1:0]  inSel124;
  logic [15:0] outData124;

  typedef struct {
    logic [7:0]  e181;
    logic [1:0]  e121;
    logic [15:0] e124;
  } exp_t;

  exp_t expQ[$];
  int   nCompared = 0;
  int   nMismatched = 0;

  demux_bank dut (
    .inClk      (inClk),
    .inRst_n    (inRst_n),
    .inData181  (inData181),
    .inSel181   (inSel181),
    .outData181 (outData181),
    .inData121  (inData121),
    .inSel121   (inSel121),
    .outData121 (outData121),
    .inData124  (inData124),
    .inSel124   (inSel124),
    .outData124 (outData124)
  );

  initial begin
    inClk = 1'b0;
    forever #5 inClk = ~inClk;
  end

  // Apply one cycle of stimulus and record what the outputs must show after
  // the following rising edge.
  task automatic step(input logic rst, input logic d181, input logic [2:0] s181,
                      input logic d121, input logic [0:0] s121,
                      input logic [3:0] d124, input logic [1:0] s124);
    exp_t e;
    @(negedge inClk);
    inRst_n   = rst;
    inData181 = d181;
    inSel181  = s181;
    inData121 = d121;
    inSel121  = s121;
    inData124 = d124;
    inSel124  = s124;
    if (!rst) begin
      e.e181 = 8'h00;
      e.e121 = 2'b00;
      e.e124 = 16'h0000;
    end else begin
      e.e181 = 8'(d181) << s181;
      e.e121 = 2'(d121) << s121;
      e.e124 = 16'(d124) << (4 * s124);
    end
    expQ.push_back(e);
  endtask

  // Monitor: compare the registered outputs against the oldest expectation.
  initial begin
    exp_t e;
    forever begin
      @(posedge inClk);
      #1;
      if (expQ.size() > 0) begin
        e = expQ.pop_front();
        nCompared++;
        if (outData181 !== e.e181) begin
          nMismatched++;
          $display("FAIL ch181 at %0t: got %h expected %h", $time, outData181, e.e181);
        end
        nCompared++;
        if (outData121 !== e.e121) begin
          nMismatched++;
          $display("FAIL ch121 at %0t: got %b expected %b", $time, outData121, e.e121);
        end
        nCompared++;
        if (outData124 !== e.e124) begin
          nMismatched++;
          $display("FAIL ch124 at %0t: got %h expected %h", $time, outData124, e.e124);
        end
      end
    end
  end

  initial begin
    inRst_n = 1'b0; inData181 = 1'b0; inSel181 = 3'd0; inData121 = 1'b0;
    inSel121 = 1'b0; inData124 = 4'h0; inSel124 = 2'd0;

    // Reset held two edges with live data on the inputs.
    step(1'b0, 1'b1, 3'd3, 1'b1, 1'b1, 4'hF, 2'd2);
    step(1'b0, 1'b1, 3'd3, 1'b1, 1'b1, 4'hF, 2'd2);

    // ch181 sweep, then data 0.
    for (int i = 0; i < 8; i++) step(1'b1, 1'b1, 3'(i), 1'b0, 1'b0, 4'h0, 2'd0);
    step(1'b1, 1'b0, 3'd6, 1'b0, 1'b0, 4'h0, 2'd0);

    // ch121 both lanes, then data 0.
    step(1'b1, 1'b0, 3'd0, 1'b1, 1'b0, 4'h0, 2'd0);
    step(1'b1, 1'b0, 3'd0, 1'b1, 1'b1, 4'h0, 2'd0);
    step(1'b1, 1'b0, 3'd0, 1'b0, 1'b1, 4'h0, 2'd0);

    // ch124 nibble sweep on lane 0, then lanes 1 and 3.
    for (int i = 0; i < 16; i++) step(1'b1, 1'b0, 3'd0, 1'b0, 1'b0, 4'(i), 2'd0);
    step(1'b1, 1'b0, 3'd0, 1'b0, 1'b0, 4'hA, 2'd1);
    step(1'b1, 1'b0, 3'd0, 1'b0, 1'b0, 4'h5, 2'd3);

    // Select and data change together: lane 0 must clear as lane 2 loads.
    step(1'b1, 1'b0, 3'd0, 1'b0, 1'b0, 4'h3, 2'd0);
    step(1'b1, 1'b0, 3'd0, 1'b0, 1'b0, 4'hC, 2'd2);

    // Reset mid-stream on ch181 lane 5, then release.
    step(1'b1, 1'b1, 3'd5, 1'b1, 1'b1, 4'h9, 2'd1);
    step(1'b0, 1'b1, 3'd5, 1'b1, 1'b1, 4'h9, 2'd1);
    step(1'b1, 1'b1, 3'd5, 1'b1, 1'b1, 4'h9, 2'd1);

    // Random traffic with occasional reset pulses.
    for (int i = 0; i < 300; i++) begin
      step(($urandom_range(0, 19) != 0), 1'($urandom), 3'($urandom), 1'($urandom),
           1'($urandom), 4'($urandom), 2'($urandom));
    end

    // Drain: every expectation must be consumed within a bounded wait.
    for (int w = 0; w < 10 && expQ.size() > 0; w++) @(posedge inClk);
    #2;
    if (expQ.size() > 0) begin
      nCompared++;
      nMismatched++;
      $display("FAIL drain: %0d expectations left, required 0", expQ.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
    $finish;
  end

endmodule
